// File: rtl/izh_pkg.sv
// Shared types and constants for the Izhikevich neuron tile and its spike decoder.
package izh_pkg;

  // Q8.9 membrane fixed-point format used by the neuron core
  localparam int unsigned FRAC_BITS = 9;
  localparam int unsigned WORD_W    = 18;

  localparam int SPIKE_TH = 30;
  localparam int REARM_TH = -40;

  localparam int unsigned EVT_TS_W = 16;

  typedef enum logic {
    ARMED,
    REFRACT
  } izh_state_e;

  typedef struct packed {
    logic [EVT_TS_W-1:0] ts;
    logic [EVT_TS_W-1:0] isi;
  } izh_evt_t;

endpackage

// File: rtl/izh_evt_fifo.sv
// Synchronous event FIFO; a push while full is still taken when a pop happens on the same edge.
module izh_evt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_q];

  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/izh_spike_decoder.sv
// Spike detector with hysteresis; queues {timestamp, inter-spike interval} events for readout.
module izh_spike_decoder
  import izh_pkg::*;
#(
  parameter int unsigned VW    = 8,
  parameter int unsigned TS_W  = 16,
  parameter int unsigned DEPTH = 4,
  parameter int          TH_HI = SPIKE_TH,
  parameter int          TH_LO = REARM_TH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic signed [VW-1:0] v_in,
  input  logic                 ovf_clr,
  output logic                 spike,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [TS_W-1:0]      evt_ts,
  output logic [TS_W-1:0]      evt_isi,
  output logic [7:0]           spike_cnt,
  output logic                 ovf
);

  localparam logic signed [VW-1:0] TH_HI_V = TH_HI[VW-1:0];
  localparam logic signed [VW-1:0] TH_LO_V = TH_LO[VW-1:0];

  logic signed [VW-1:0] v_q, v_d;
  logic [TS_W-1:0]      ts_q, ts_d, isi_q, isi_d;
  izh_state_e           state_q, state_d;
  logic                 spike_q, spike_d, ovf_q, ovf_d;
  logic [7:0]           cnt_q, cnt_d;

  logic                    detect, pop, fifo_full, fifo_empty;
  logic [2*TS_W-1:0]       fifo_rdata;
  logic [$clog2(DEPTH):0]  fifo_count;

  always_comb begin
    v_d     = v_q;
    ts_d    = ts_q;
    isi_d   = isi_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    detect  = 1'b0;
    if (ena) begin
      v_d   = v_in;
      ts_d  = ts_q + TS_W'(1);
      isi_d = (isi_q == '1) ? isi_q : isi_q + TS_W'(1);
      unique case (state_q)
        ARMED: begin
          if (v_q >= TH_HI_V) begin
            detect  = 1'b1;
            state_d = REFRACT;
            isi_d   = TS_W'(1);
          end
        end
        REFRACT: begin
          if (v_q <= TH_LO_V) state_d = ARMED;
        end
      endcase
    end
    spike_d = detect;
    if (detect) cnt_d = cnt_q + 8'd1;
    pop = evt_ready && !fifo_empty;
    // A same-edge drop outranks the clear so no lost event goes unreported.
    if (ovf_clr) ovf_d = 1'b0;
    if (detect && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      ts_q    <= '0;
      isi_q   <= '1;
      state_q <= ARMED;
      spike_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      v_q     <= v_d;
      ts_q    <= ts_d;
      isi_q   <= isi_d;
      state_q <= state_d;
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  izh_evt_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * TS_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (detect),
    .pop_i   (pop),
    .wdata_i ({ts_q, isi_q}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign evt_valid = (fifo_count != '0);
  assign evt_ts    = evt_valid ? fifo_rdata[2*TS_W-1:TS_W] : '0;
  assign evt_isi   = evt_valid ? fifo_rdata[TS_W-1:0] : '0;
  assign spike     = spike_q;
  assign spike_cnt = cnt_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_izh_spike_decoder.sv
// Self-checking bench: a reference model predicts events into a scoreboard queue checked on pop.
module tb_izh_spike_decoder;
  import izh_pkg::*;

  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ena = 1'b0;
  logic signed [7:0] v_in = '0;
  logic              ovf_clr = 1'b0;
  logic              evt_ready = 1'b0;
  logic              spike, evt_valid, ovf;
  logic [15:0]       evt_ts, evt_isi;
  logic [7:0]        spike_cnt;

  izh_spike_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .v_in      (v_in),
    .ovf_clr   (ovf_clr),
    .spike     (spike),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ts    (evt_ts),
    .evt_isi   (evt_isi),
    .spike_cnt (spike_cnt),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  izh_evt_t exp_q[$];
  int m_vq, m_ts, m_isi, m_cnt;
  bit m_refr, m_spike, m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_vq = 0; m_ts = 0; m_isi = 16'hFFFF; m_cnt = 0;
    m_refr = 0; m_spike = 0; m_ovf = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b1; v_in = -8'sd65; evt_ready = 1'b0; ovf_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("rst_spike", 32'(spike), 32'd0);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_ts", 32'(evt_ts), 32'd0);
    check("rst_isi", 32'(evt_isi), 32'd0);
    check("rst_cnt", 32'(spike_cnt), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
  endtask

  // One clock edge: predict its effect, drive inputs, then compare outputs after the edge.
  task automatic step(input int v, input bit e, input bit r, input bit clr);
    izh_evt_t ev;
    bit pop, full, det, drop;
    full = (exp_q.size() == DEPTH);
    pop  = r && (exp_q.size() != 0);
    if (pop) begin
      ev = exp_q.pop_front();
      check("pop_ts", 32'(evt_ts), 32'(ev.ts));
      check("pop_isi", 32'(evt_isi), 32'(ev.isi));
    end
    det  = e && !m_refr && (m_vq >= 30);
    drop = 0;
    if (det) begin
      if (!full || pop) begin
        ev.ts  = m_ts[15:0];
        ev.isi = m_isi[15:0];
        exp_q.push_back(ev);
      end else drop = 1;
    end
    if (clr)  m_ovf = 0;
    if (drop) m_ovf = 1;
    m_spike = det;
    if (det) m_cnt = (m_cnt + 1) % 256;
    if (e) begin
      if (det) m_refr = 1;
      else if (m_refr && m_vq <= -40) m_refr = 0;
      m_vq  = v;
      m_ts  = (m_ts + 1) % 65536;
      m_isi = det ? 1 : ((m_isi == 16'hFFFF) ? 16'hFFFF : m_isi + 1);
    end
    v_in = v[7:0]; ena = e; evt_ready = r; ovf_clr = clr;
    @(posedge clk); #1;
    check("spike", 32'(spike), 32'(m_spike));
    check("valid", 32'(evt_valid), 32'(exp_q.size() != 0));
    check("cnt", 32'(spike_cnt), 32'(m_cnt));
    check("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic spike_once(input bit r);
    step(31, 1, r, 0);
    step(-65, 1, r, 0);
    step(-65, 1, r, 0);
  endtask

  initial begin
    int base;
    model_reset();

    // Quiescent membrane: nothing happens
    do_reset();
    for (int i = 0; i < 20; i++) step(-65, 1, 1, 0);
    check("quiet_cnt", 32'(spike_cnt), 32'd0);

    // Ramp: crossings sampled at edges 10 and 60 after reset
    do_reset();
    for (int i = 0; i < 70; i++) step((i == 10 || i == 60) ? 31 : -65, 1, 0, 0);
    check("ramp_cnt", 32'(spike_cnt), 32'd2);
    check("ramp_ts0", 32'(evt_ts), 32'd11);
    check("ramp_isi0", 32'(evt_isi), 32'hFFFF);
    step(-65, 1, 1, 0);
    check("ramp_ts1", 32'(evt_ts), 32'd61);
    check("ramp_isi1", 32'(evt_isi), 32'd50);
    step(-65, 1, 1, 0);

    // Hysteresis: no re-arm above -40; boundaries 30 and -40 inclusive
    base = spike_cnt;
    step(31, 1, 1, 0); step(-20, 1, 1, 0); step(35, 1, 1, 0);
    step(-20, 1, 1, 0); step(31, 1, 1, 0); step(-20, 1, 1, 0);
    step(-20, 1, 1, 0);
    check("hyst_one", 32'(spike_cnt), 32'(base + 1));
    step(-41, 1, 1, 0); step(30, 1, 1, 0); step(-20, 1, 1, 0); step(-20, 1, 1, 0);
    check("hyst_two", 32'(spike_cnt), 32'(base + 2));
    step(-40, 1, 1, 0); step(30, 1, 1, 0); step(-65, 1, 1, 0); step(-65, 1, 1, 0);
    check("hyst_three", 32'(spike_cnt), 32'(base + 3));

    // Overflow, drain, clear, then accepted push while full with a same-edge pop
    do_reset();
    for (int i = 0; i < 5; i++) spike_once(0);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_cnt", 32'(spike_cnt), 32'd5);
    for (int i = 0; i < 4; i++) step(-65, 1, 1, 0);
    check("drained", 32'(evt_valid), 32'd0);
    step(-65, 1, 0, 1);
    check("ovf_clr", 32'(ovf), 32'd0);
    for (int i = 0; i < 4; i++) spike_once(0);
    step(31, 1, 0, 0);
    step(-65, 1, 1, 0);
    step(-65, 1, 0, 0);
    check("full_pop_ovf", 32'(ovf), 32'd0);
    check("full_pop_cnt", 32'(spike_cnt), 32'd10);
    for (int i = 0; i < 5; i++) step(-65, 1, 1, 0);

    // Enable gap excluded from ISI and timestamp
    do_reset();
    step(31, 1, 0, 0);
    for (int i = 0; i < 9; i++) step(-65, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(31, 0, 0, 0);
    step(31, 1, 0, 0);
    step(-65, 1, 0, 0);
    check("ena_ts0", 32'(evt_ts), 32'd1);
    step(-65, 1, 1, 0);
    check("ena_ts1", 32'(evt_ts), 32'd11);
    check("ena_isi1", 32'(evt_isi), 32'd10);
    spike_once(0);

    // Mid-run reset discards two queued events
    check("pre_rst_valid", 32'(evt_valid), 32'd1);
    do_reset();
    spike_once(0);
    check("post_rst_isi", 32'(evt_isi), 32'hFFFF);
    step(-65, 1, 1, 0);
    step(-65, 1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
